// File: rtl/ps2_rx.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module     : ps2_rx
// Description: PS/2 device-to-host receiver. Synchronises and glitch-filters
//              the bus, deserialises 11-bit frames and strobes out good bytes.
//              Optional inter-bit watchdog enabled by defining PS2_RX_TIMEOUT_EN.
// Revision   : 1.0 - initial release
// ============================================================================
module ps2_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TIMEOUT_US  = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_err
);

  localparam int TIMEOUT_CYC = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
  localparam int FW          = (FILT_LEN > 2) ? $clog2(FILT_LEN) : 1;
  localparam logic [FW-1:0] FILT_MAX = FW'(FILT_LEN - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  generate
    if (SYNC_STAGES < 2 || FILT_LEN < 2 || TIMEOUT_CYC < 2) begin : g_bad_param
      $error("ps2_rx: illegal parameter combination");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   sclk;
  logic                   sdata;
  logic                   filt_clk;
  logic [FW-1:0]          filt_cnt;
  logic                   fe;
  logic [1:0]             state;
  logic [2:0]             bitcnt;
  logic [7:0]             shreg;
  logic                   parity;
  logic                   timeout;

  assign sclk  = clk_sync[SYNC_STAGES-1];
  assign sdata = data_sync[SYNC_STAGES-1];

  // Synchronisers come out of reset at the idle level so release is edge-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // Filtered clock follows only after FILT_LEN consecutive samples of the new level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      fe       <= 1'b0;
    end else begin
      fe <= 1'b0;
      if (sclk == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_MAX) begin
        filt_clk <= sclk;
        filt_cnt <= '0;
        fe       <= ~sclk;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (state == IDLE || fe || timeout) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout = (state != IDLE) && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  // Timeout has priority over a coincident falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bitcnt  <= 3'd0;
      shreg   <= 8'd0;
      parity  <= 1'b0;
      rx_data <= 8'd0;
      rx_done <= 1'b0;
      rx_err  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      rx_err  <= 1'b0;
      if (timeout) begin
        state  <= IDLE;
        bitcnt <= 3'd0;
        rx_err <= 1'b1;
      end else if (fe) begin
        case (state)
          IDLE: begin
            if (!sdata) begin
              state  <= DATA;
              bitcnt <= 3'd0;
            end
          end
          DATA: begin
            shreg  <= {sdata, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            parity <= sdata;
            state  <= STOP;
          end
          STOP: begin
            if (sdata && (^{shreg, parity})) begin
              rx_data <= shreg;
              rx_done <= 1'b1;
            end else begin
              rx_err <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module     : tb_ps2_rx
// Description: Self-checking bench for ps2_rx with a frame-level reference model.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_ps2_rx;

  localparam int HALF        = 20;
  localparam int LATENCY     = 2 + 4 + 1;
  localparam int TIMEOUT_CYC = 100 * 200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_err;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         fall_cyc = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         both_cnt = 0;
  int         done_cyc = 0;
  int         err_cyc = 0;
  logic [7:0] done_q[$];
  logic [7:0] last_good = 8'h00;

  ps2_rx #(
    .SYNC_STAGES(2),
    .FILT_LEN   (4),
    .CLK_FREQ_HZ(100_000_000),
    .TIMEOUT_US (200)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rx_data (rx_data),
    .rx_done (rx_done),
    .rx_err  (rx_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_done) begin
      if (done_cnt == 0) done_cyc = cyc;
      done_cnt++;
      done_q.push_back(rx_data);
    end
    if (rx_err) begin
      if (err_cnt == 0) err_cyc = cyc;
      err_cnt++;
    end
    if (rx_done && rx_err) both_cnt++;
  end

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic p, input logic s);
    return {s, p, d, 1'b0};
  endfunction

  // A frame is good when the stop bit is 1 and data plus parity hold an odd number of ones.
  function automatic logic frame_ok(input logic [10:0] f);
    return f[10] && ($countones(f[9:1]) % 2 == 1);
  endfunction

  task automatic clr();
    @(posedge clk);
    done_cnt = 0;
    err_cnt  = 0;
    done_q.delete();
  endtask

  task automatic send_bits(input logic [10:0] f, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk  = 1'b0;
      fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    @(negedge clk);
    ps2_data = 1'b1;
  endtask

  task automatic settle();
    repeat (10) @(posedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if (rx_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_rx_data: got %h want 00", rx_data);
    end
    vectors++;
    if (rx_done !== 1'b0 || rx_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_strobes: got done=%b err=%b want 0 0", rx_done, rx_err);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (rx_done !== 1'b0 || rx_err !== 1'b0) begin
      miscompares++;
      $display("FAIL release_strobes: got done=%b err=%b want 0 0", rx_done, rx_err);
    end
  endtask

  task automatic test_single();
    clr();
    send_bits(mk_frame(8'h1D, 1'b1, 1'b1), 0, 10);
    settle();
    last_good = 8'h1D;
    vectors++;
    if (done_cnt !== 1 || err_cnt !== 0) begin
      miscompares++;
      $display("FAIL single_strobes: got done=%0d err=%0d want 1 0", done_cnt, err_cnt);
    end
    vectors++;
    if (rx_data !== 8'h1D) begin
      miscompares++;
      $display("FAIL single_data: got %h want 1d", rx_data);
    end
    vectors++;
    if (done_cyc - fall_cyc !== LATENCY) begin
      miscompares++;
      $display("FAIL single_latency: got %0d want %0d", done_cyc - fall_cyc, LATENCY);
    end
  endtask

  task automatic test_back_to_back();
    clr();
    send_bits(mk_frame(8'hF0, ~^8'hF0, 1'b1), 0, 10);
    send_bits(mk_frame(8'h1C, ~^8'h1C, 1'b1), 0, 10);
    settle();
    last_good = 8'h1C;
    vectors++;
    if (done_q.size() !== 2) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d want 2", done_q.size());
    end else begin
      vectors++;
      if (done_q[0] !== 8'hF0 || done_q[1] !== 8'h1C) begin
        miscompares++;
        $display("FAIL b2b_data: got %h %h want f0 1c", done_q[0], done_q[1]);
      end
    end
  endtask

  task automatic test_errors();
    send_bits(mk_frame(8'h1B, ~^8'h1B, 1'b1), 0, 10);
    last_good = 8'h1B;
    clr();
    send_bits(mk_frame(8'h23, ^8'h23, 1'b1), 0, 10);
    settle();
    vectors++;
    if (done_cnt !== 0 || err_cnt !== 1 || rx_data !== last_good) begin
      miscompares++;
      $display("FAIL parity_err: got done=%0d err=%0d data=%h want 0 1 %h",
               done_cnt, err_cnt, rx_data, last_good);
    end
    clr();
    send_bits(mk_frame(8'h2D, ~^8'h2D, 1'b0), 0, 10);
    settle();
    vectors++;
    if (done_cnt !== 0 || err_cnt !== 1 || rx_data !== last_good) begin
      miscompares++;
      $display("FAIL stop_err: got done=%0d err=%0d data=%h want 0 1 %h",
               done_cnt, err_cnt, rx_data, last_good);
    end
  endtask

  task automatic test_glitch();
    clr();
    @(negedge clk);
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_data = 1'b1;
    settle();
    vectors++;
    if (done_cnt !== 0 || err_cnt !== 0) begin
      miscompares++;
      $display("FAIL glitch_strobes: got done=%0d err=%0d want 0 0", done_cnt, err_cnt);
    end
    clr();
    send_bits(mk_frame(8'h1D, 1'b1, 1'b1), 0, 10);
    settle();
    last_good = 8'h1D;
    vectors++;
    if (done_cnt !== 1 || err_cnt !== 0 || rx_data !== 8'h1D) begin
      miscompares++;
      $display("FAIL glitch_next_frame: got done=%0d err=%0d data=%h want 1 0 1d",
               done_cnt, err_cnt, rx_data);
    end
  endtask

  task automatic test_reset_mid_frame();
    clr();
    send_bits(mk_frame(8'hA7, ~^8'hA7, 1'b1), 0, 4);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    last_good = 8'h00;
    vectors++;
    if (rx_data !== 8'h00 || done_cnt !== 0 || err_cnt !== 0) begin
      miscompares++;
      $display("FAIL midreset_state: got data=%h done=%0d err=%0d want 00 0 0",
               rx_data, done_cnt, err_cnt);
    end
    send_bits(mk_frame(8'h05, ~^8'h05, 1'b1), 0, 10);
    settle();
    last_good = 8'h05;
    vectors++;
    if (done_cnt !== 1 || err_cnt !== 0 || rx_data !== 8'h05) begin
      miscompares++;
      $display("FAIL midreset_frame: got done=%0d err=%0d data=%h want 1 0 05",
               done_cnt, err_cnt, rx_data);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 14; n++) begin
      logic [7:0]  d;
      logic        p;
      logic        s;
      logic [10:0] f;
      int          kind;
      d    = 8'($urandom);
      kind = $urandom_range(0, 3);
      p    = (kind == 1) ? ^d : ~^d;
      s    = (kind == 2) ? 1'b0 : 1'b1;
      f    = mk_frame(d, p, s);
      clr();
      send_bits(f, 0, 10);
      settle();
      if (frame_ok(f)) last_good = d;
      vectors++;
      if (done_cnt !== (frame_ok(f) ? 1 : 0) || err_cnt !== (frame_ok(f) ? 0 : 1)) begin
        miscompares++;
        $display("FAIL rand_strobes[%0d]: frame %h got done=%0d err=%0d want ok=%b",
                 n, f, done_cnt, err_cnt, frame_ok(f));
      end
      vectors++;
      if (rx_data !== last_good) begin
        miscompares++;
        $display("FAIL rand_data[%0d]: got %h want %h", n, rx_data, last_good);
      end
    end
  endtask

`ifdef PS2_RX_TIMEOUT_EN
  task automatic test_truncated();
    clr();
    send_bits(mk_frame(8'h3C, ~^8'h3C, 1'b1), 0, 3);
    repeat (TIMEOUT_CYC + 200) @(posedge clk);
    vectors++;
    if (err_cnt !== 1 || done_cnt !== 0 || rx_data !== last_good) begin
      miscompares++;
      $display("FAIL timeout_err: got err=%0d done=%0d data=%h want 1 0 %h",
               err_cnt, done_cnt, rx_data, last_good);
    end
    vectors++;
    if (err_cyc - fall_cyc < TIMEOUT_CYC || err_cyc - fall_cyc > TIMEOUT_CYC + 20) begin
      miscompares++;
      $display("FAIL timeout_delay: got %0d want about %0d", err_cyc - fall_cyc, TIMEOUT_CYC);
    end
    clr();
    send_bits(mk_frame(8'h06, ~^8'h06, 1'b1), 0, 10);
    settle();
    last_good = 8'h06;
    vectors++;
    if (done_cnt !== 1 || err_cnt !== 0 || rx_data !== 8'h06) begin
      miscompares++;
      $display("FAIL timeout_next: got done=%0d err=%0d data=%h want 1 0 06",
               done_cnt, err_cnt, rx_data);
    end
  endtask
`else
  task automatic test_truncated();
    logic [10:0] f;
    f = mk_frame(8'h3C, ~^8'h3C, 1'b1);
    clr();
    send_bits(f, 0, 3);
    repeat (300) @(posedge clk);
    vectors++;
    if (err_cnt !== 0 || done_cnt !== 0) begin
      miscompares++;
      $display("FAIL stall_strobes: got err=%0d done=%0d want 0 0", err_cnt, done_cnt);
    end
    send_bits(f, 4, 10);
    settle();
    last_good = 8'h3C;
    vectors++;
    if (done_cnt !== 1 || err_cnt !== 0 || rx_data !== 8'h3C) begin
      miscompares++;
      $display("FAIL stall_resume: got done=%0d err=%0d data=%h want 1 0 3c",
               done_cnt, err_cnt, rx_data);
    end
  endtask
`endif

  task automatic test_exclusive();
    vectors++;
    if (both_cnt !== 0) begin
      miscompares++;
      $display("FAIL done_err_overlap: got %0d cycles want 0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_errors();
    test_glitch();
    test_reset_mid_frame();
    test_random();
    test_truncated();
    test_exclusive();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
